// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared pipeline types: control bundle, ALU op encodings,
//               datapath default width and ID/EX stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;

    // ALU operation encodings carried in ctrl_t.aluOp
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Decoded control bundle travelling down the pipeline
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic [3:0] aluOp;
    } ctrl_t;

    // All-zero control: no write enables, safe for bubbles and empty slots
    localparam ctrl_t CTRL_NOP = '0;

    // ID/EX stage sequencing
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } stage_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detector. Flags when the load
//               sitting in EX writes a non-x0 register that the instruction
//               in ID actually reads.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                 i_ex_valid,
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_id_valid,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    output logic                 o_hazard
);

    logic w_load_in_ex;
    logic w_rs1_match;
    logic w_rs2_match;

    // x0 is hard-wired to zero, so a load targeting it never produces data
    assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
    assign w_rs1_match  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_match  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_hazard     = w_load_in_ex & i_id_valid & (w_rs1_match | w_rs2_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall generation,
//               flush handling, RUN/BUBBLE sequencing and saturating
//               stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  ctrl_t                id_ctrl,
    input  logic                 ex_flush,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output ctrl_t                ex_ctrl,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic                 r_ex_valid;
    logic [XLEN-1:0]      r_ex_pc;
    logic [REG_IDX_W-1:0] r_ex_rs1;
    logic [REG_IDX_W-1:0] r_ex_rs2;
    logic [REG_IDX_W-1:0] r_ex_rd;
    logic [XLEN-1:0]      r_ex_rs1_data;
    logic [XLEN-1:0]      r_ex_rs2_data;
    logic [XLEN-1:0]      r_ex_imm;
    ctrl_t                r_ex_ctrl;
    stage_state_e         r_state;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_bubble;

    hazard_detect u_hazard_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_ctrl.memRead),
        .i_ex_rd       (r_ex_rd),
        .i_id_valid    (id_valid),
        .i_id_use_rs1  (id_use_rs1),
        .i_id_use_rs2  (id_use_rs2),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .o_hazard      (w_hazard)
    );

    // A flush already kills the dependent instruction, so it masks the stall
    assign w_stall  = w_hazard & ~ex_flush;
    assign w_bubble = ex_flush | w_stall;

    // Pipeline register: bubble on flush/stall, otherwise capture decode.
    // Data fields are left untouched in a bubble since nothing consumes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_ctrl     <= CTRL_NOP;
        end else if (w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= CTRL_NOP;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_pc       <= id_pc;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rd       <= id_rd;
            r_ex_rs1_data <= id_rs1_data;
            r_ex_rs2_data <= id_rs2_data;
            r_ex_imm      <= id_imm;
            r_ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    // RUN/BUBBLE sequencing; a flush arriving during BUBBLE keeps it there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_stall) begin
                        r_state <= ST_BUBBLE;
                    end
                end
                ST_BUBBLE: begin
                    if (!ex_flush) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating event counters: hold at all-ones rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_flush && r_ex_valid && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // The bubble clears memRead, so a hazard cannot re-trigger while in BUBBLE
    a_no_stall_in_bubble : assert property (
        @(posedge clk) disable iff (!rst_n) (r_state == ST_BUBBLE) |-> !w_stall
    );

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_rd       = r_ex_rd;
    assign ex_rs1_data = r_ex_rs1_data;
    assign ex_rs2_data = r_ex_rs2_data;
    assign ex_imm      = r_ex_imm;
    assign ex_ctrl     = r_ex_ctrl;
    assign stall       = w_stall;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed vector table,
//               reset/saturation sequences and randomized traffic against a
//               behavioural model. Two instances (16-bit and 2-bit counters)
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import riscv_pkg::*;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        ctrl_t       ctrl;
        logic        flush;
        logic [31:0] pc, d1, d2, imm;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_rd;
        ctrl_t       e_ctrl;
        logic [31:0] e_pc;
        int          e_scnt;
        int          e_fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs1, id_use_rs2, ex_flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    ctrl_t       id_ctrl;

    logic ex_valid, stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    ctrl_t       ex_ctrl;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_ex_valid, s_stall;
    logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    ctrl_t       s_ex_ctrl;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
        .ex_rd(s_ex_rd), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
        .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl), .stall(s_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // ---------------- behavioural model of the EX slot ----------------
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    ctrl_t       m_ctrl;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    int          m_scnt, m_fcnt, m_scnt_s, m_fcnt_s;

    function automatic int sat_inc(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // A load in EX whose non-x0 destination is read by a valid ID instruction
    function automatic bit m_hazard(stim_t s);
        bit reads = (s.use1 && s.rs1 == m_rd) || (s.use2 && s.rs2 == m_rd);
        return m_valid && m_ctrl.memRead && (m_rd != 5'd0) && s.valid && reads;
    endfunction

    function automatic bit m_stall(stim_t s);
        return m_hazard(s) && !s.flush;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
        m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
    endtask

    task automatic model_step(stim_t s);
        bit st = m_stall(s);
        if (st) begin
            m_scnt   = sat_inc(m_scnt, 65535);
            m_scnt_s = sat_inc(m_scnt_s, 3);
        end
        if (s.flush && m_valid) begin
            m_fcnt   = sat_inc(m_fcnt, 65535);
            m_fcnt_s = sat_inc(m_fcnt_s, 3);
        end
        if (s.flush || st) begin
            m_valid = 1'b0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ctrl = '0;
        end else begin
            m_valid = s.valid; m_rd = s.rd; m_rs1 = s.rs1; m_rs2 = s.rs2;
            m_ctrl  = s.valid ? s.ctrl : '0;
            m_pc = s.pc; m_d1 = s.d1; m_d2 = s.d2; m_imm = s.imm;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t mk_ctrl(bit rw, bit mr, bit m2r, bit asrc, logic [3:0] op);
        ctrl_t c;
        c = '0;
        c.regWrite = rw; c.memRead = mr; c.memToReg = m2r; c.aluSrc = asrc; c.aluOp = op;
        return c;
    endfunction

    function automatic stim_t mk_stim(bit v, int rs1, int rs2, int rd, bit u1, bit u2,
                                      ctrl_t c, bit fl, logic [31:0] pc);
        stim_t s;
        s.valid = v; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.use1 = u1; s.use2 = u2; s.ctrl = c; s.flush = fl; s.pc = pc;
        s.d1 = pc ^ 32'h5A5A_0000; s.d2 = ~pc; s.imm = pc << 3;
        return s;
    endfunction

    task automatic apply(stim_t s);
        id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_use_rs1 = s.use1; id_use_rs2 = s.use2; id_ctrl = s.ctrl;
        ex_flush = s.flush; id_pc = s.pc; id_rs1_data = s.d1;
        id_rs2_data = s.d2; id_imm = s.imm;
    endtask

    // One clock: drive, sample stall mid-cycle, advance, compare EX slot
    task automatic run_cycle(input stim_t s, output logic got_stall);
        apply(s);
        #2;
        got_stall = stall;
        chk("stall", stall, m_stall(s));
        chk("stall_small", s_stall, m_stall(s));
        @(posedge clk);
        model_step(s);
        #1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_rd", ex_rd, m_rd);
        chk("ex_rs1", ex_rs1, m_rs1);
        chk("ex_rs2", ex_rs2, m_rs2);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
        chk("stall_cnt_small", s_stall_cnt, m_scnt_s);
        chk("flush_cnt_small", s_flush_cnt, m_fcnt_s);
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1_data", ex_rs1_data, m_d1);
            chk("ex_rs2_data", ex_rs2_data, m_d2);
            chk("ex_imm", ex_imm, m_imm);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    ctrl_t C_ADD, C_SUB, C_LW, C_NOP;
    vec_t  vt[12];
    stim_t st_add;
    logic  gs;

    initial begin
        C_ADD = mk_ctrl(1, 0, 0, 0, ALU_ADD);
        C_SUB = mk_ctrl(1, 0, 0, 0, ALU_SUB);
        C_LW  = mk_ctrl(1, 1, 1, 1, ALU_ADD);
        C_NOP = '0;
        apply(mk_stim(0, 0, 0, 0, 0, 0, C_NOP, 0, 32'h0));

        // reset state, asynchronous (before any clock edge)
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed table: inputs and hand-derived expectations ----
        //                stim: v rs1 rs2 rd u1 u2 ctrl flush pc     | stall valid rd ctrl pc scnt fcnt
        vt[0]  = '{mk_stim(1, 1, 2, 5, 1, 1, C_ADD, 0, 32'h100), 0, 1, 5, C_ADD, 32'h100, 0, 0}; // add x5
        vt[1]  = '{mk_stim(1, 5, 3, 6, 1, 1, C_SUB, 0, 32'h104), 0, 1, 6, C_SUB, 32'h104, 0, 0}; // sub x6,x5
        vt[2]  = '{mk_stim(1, 1, 0, 5, 1, 0, C_LW,  0, 32'h108), 0, 1, 5, C_LW,  32'h108, 0, 0}; // lw x5
        vt[3]  = '{mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 0, 32'h10C), 1, 0, 0, C_NOP, 32'h0,   1, 0}; // stall
        vt[4]  = '{mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 0, 32'h10C), 0, 1, 7, C_ADD, 32'h10C, 1, 0}; // advance
        vt[5]  = '{mk_stim(1, 1, 0, 0, 1, 0, C_LW,  0, 32'h110), 0, 1, 0, C_LW,  32'h110, 1, 0}; // lw x0
        vt[6]  = '{mk_stim(1, 0, 1, 7, 1, 1, C_ADD, 0, 32'h114), 0, 1, 7, C_ADD, 32'h114, 1, 0}; // no stall
        vt[7]  = '{mk_stim(1, 2, 0, 5, 1, 0, C_LW,  0, 32'h118), 0, 1, 5, C_LW,  32'h118, 1, 0}; // lw x5
        vt[8]  = '{mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 1, 32'h11C), 0, 0, 0, C_NOP, 32'h0,   1, 1}; // flush+hazard
        vt[9]  = '{mk_stim(0, 3, 4, 0, 1, 1, C_ADD, 0, 32'h120), 0, 0, 0, C_NOP, 32'h0,   1, 1}; // empty slot
        vt[10] = '{mk_stim(1, 1, 2, 8, 1, 1, C_ADD, 1, 32'h124), 0, 0, 0, C_NOP, 32'h0,   1, 1}; // flush, EX empty
        vt[11] = '{mk_stim(1, 1, 2, 8, 1, 1, C_ADD, 0, 32'h128), 0, 1, 8, C_ADD, 32'h128, 1, 1};

        for (int i = 0; i < 12; i++) begin
            run_cycle(vt[i].in, gs);
            chk($sformatf("vec%0d_stall", i), gs, vt[i].e_stall);
            chk($sformatf("vec%0d_valid", i), ex_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_rd", i), ex_rd, vt[i].e_rd);
            chk($sformatf("vec%0d_ctrl", i), ex_ctrl, vt[i].e_ctrl);
            chk($sformatf("vec%0d_scnt", i), stall_cnt, vt[i].e_scnt);
            chk($sformatf("vec%0d_fcnt", i), flush_cnt, vt[i].e_fcnt);
            if (vt[i].e_valid)
                chk($sformatf("vec%0d_pc", i), ex_pc, vt[i].e_pc);
        end

        // ---- reset asserted in the middle of a stall ----
        run_cycle(mk_stim(1, 1, 0, 5, 1, 0, C_LW, 0, 32'h200), gs);
        st_add = mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 0, 32'h204);
        apply(st_add);
        @(negedge clk);
        chk("midrst_stall_before", stall, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_ex_valid", ex_valid, 1'b0);
        chk("midrst_ex_rd", ex_rd, 0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_flush_cnt", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(st_add, gs);
        chk("postrst_loaded", ex_pc, 32'h204);
        // back in RUN: a fresh load-use pair must stall again
        run_cycle(mk_stim(1, 1, 0, 6, 1, 0, C_LW, 0, 32'h208), gs);
        run_cycle(mk_stim(1, 6, 1, 9, 1, 1, C_ADD, 0, 32'h20C), gs);
        chk("postrst_stall", gs, 1'b1);

        // ---- counter saturation: 5 stalls and 5 valid flushes ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_cycle(mk_stim(1, 1, 0, 5, 1, 0, C_LW, 0, 32'h300 + 32'(k * 16)), gs);
            run_cycle(mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 0, 32'h304 + 32'(k * 16)), gs);
            run_cycle(mk_stim(1, 5, 1, 7, 1, 1, C_ADD, 0, 32'h304 + 32'(k * 16)), gs);
        end
        chk("sat_stall_small", s_stall_cnt, 3);
        chk("sat_stall_big", stall_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            run_cycle(mk_stim(1, 1, 2, 3, 1, 1, C_ADD, 0, 32'h400 + 32'(k * 8)), gs);
            run_cycle(mk_stim(1, 1, 2, 4, 1, 1, C_ADD, 1, 32'h404 + 32'(k * 8)), gs);
        end
        chk("sat_flush_small", s_flush_cnt, 3);
        chk("sat_flush_big", flush_cnt, 5);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            stim_t r;
            r.valid = ($urandom_range(0, 4) != 0);
            r.rs1   = 5'($urandom_range(0, 3));
            r.rs2   = 5'($urandom_range(0, 3));
            r.rd    = 5'($urandom_range(0, 3));
            r.use1  = 1'($urandom_range(0, 1));
            r.use2  = 1'($urandom_range(0, 1));
            r.ctrl  = ctrl_t'(10'($urandom));
            r.ctrl.memRead = 1'($urandom_range(0, 1));
            r.flush = ($urandom_range(0, 7) == 0);
            r.pc    = $urandom;
            r.d1    = $urandom;
            r.d2    = $urandom;
            r.imm   = $urandom;
            run_cycle(r, gs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
